// File: rtl/serial_adder_fsm_pkg.sv
// Shared definitions for the multi-cycle serial adder: state encoding and count sizing.
package serial_adder_fsm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Count register must hold 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fsm_adder_chunk.sv
// Combinational ripple of full adders covering one chunk of the serial addition.
module adder_chunk #(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             c_i,
  output logic [Width-1:0] s_o,
  output logic             c_o,
  output logic             c_top_o
);

  logic [Width:0] c;

  // Ripple carry from bit 0 upward; c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < Width; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = c[Width];
  assign c_top_o = c[Width-1];

endmodule

// File: rtl/serial_adder_fsm.sv
// Multi-cycle adder: sums WIDTH-bit operands BITS_PER_CYCLE bits per clock with
// a start/busy/done handshake and registered unsigned carry and signed overflow.
module serial_adder_fsm
  import serial_adder_fsm_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  if (WIDTH < 2 || BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_err
    $error("serial_adder_fsm: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = cnt_width(N);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]        psum_q, psum_d;
  logic                    carry_q, carry_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]        sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [BITS_PER_CYCLE-1:0] ch_sum;
  logic                      ch_cout;
  logic                      ch_ctop;
  logic [WIDTH-1:0]          psum_next;

  adder_chunk #(
    .Width (BITS_PER_CYCLE)
  ) u_adder_chunk (
    .a_i     (a_q[BITS_PER_CYCLE-1:0]),
    .b_i     (b_q[BITS_PER_CYCLE-1:0]),
    .c_i     (carry_q),
    .s_o     (ch_sum),
    .c_o     (ch_cout),
    .c_top_o (ch_ctop)
  );

  // New chunk enters at the top so the LSB chunk ends up aligned at bit 0 after N shifts.
  assign psum_next = (psum_q >> BITS_PER_CYCLE) | (WIDTH'(ch_sum) << (WIDTH - BITS_PER_CYCLE));

  // Next-state and datapath updates for IDLE/RUN/DONE sequencing.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        // DONE accepts a new start exactly like IDLE for back-to-back issue.
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StRun: begin
        psum_d  = psum_next;
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        carry_d = ch_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          sum_d   = psum_next;
          cout_d  = ch_cout;
          ovf_d   = ch_ctop ^ ch_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset aborts any addition in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench: a 1-bit-per-cycle and a 4-bit-per-cycle instance driven from a vector table
// plus hand-written sequences for ignored start, back-to-back issue and mid-run reset.
module tb_serial_adder_fsm;

  logic       clk;
  logic       rst_n;
  logic       start1, start4;
  logic [7:0] a, b;
  logic       cin;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[9];

  serial_adder_fsm #(
    .WIDTH          (8),
    .BITS_PER_CYCLE (1)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy1),
    .done     (done1),
    .sum      (sum1),
    .cout     (cout1),
    .overflow (ovf1)
  );

  serial_adder_fsm #(
    .WIDTH          (8),
    .BITS_PER_CYCLE (4)
  ) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy4),
    .done     (done4),
    .sum      (sum4),
    .cout     (cout4),
    .overflow (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation on the chosen instance and check latency, result and done pulse width.
  task automatic run_op(input bit w4, input vec_t v, input string tag);
    int lat;
    bit busy_bad;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin;
    if (w4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    // Operands change after acceptance; the result must not follow them.
    a = ~v.a; b = ~v.b; cin = ~v.cin;
    lat = 0;
    busy_bad = 1'b0;
    while (!(w4 ? done4 : done1) && lat < 40) begin
      if (!(w4 ? busy4 : busy1)) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), w4 ? 32'd2 : 32'd8);
    check({tag, " busy during run"}, 32'(busy_bad), 32'd0);
    check({tag, " sum"}, 32'(w4 ? sum4 : sum1), 32'(v.sum));
    check({tag, " cout"}, 32'(w4 ? cout4 : cout1), 32'(v.cout));
    check({tag, " overflow"}, 32'(w4 ? ovf4 : ovf1), 32'(v.ovf));
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(w4 ? done4 : done1), 32'd0);
    check({tag, " sum held"}, 32'(w4 ? sum4 : sum1), 32'(v.sum));
  endtask

  initial begin
    int lat;
    int gap;
    bit seen;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and idle without start.
    check("reset busy", 32'({busy1, busy4}), 32'd0);
    check("reset done", 32'({done1, done4}), 32'd0);
    check("reset sum", 32'({sum1, sum4}), 32'd0);
    check("reset cout/ovf", 32'({cout1, ovf1, cout4, ovf4}), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done1 || done4 || busy1 || busy4) seen = 1'b1;
    end
    check("idle no activity", 32'(seen), 32'd0);

    for (int i = 0; i < 9; i++) run_op(1'b0, vecs[i], $sformatf("bpc1 vec%0d", i));
    for (int i = 0; i < 9; i++) run_op(1'b1, vecs[i], $sformatf("bpc4 vec%0d", i));

    // Start pulsed with new operands while running is ignored.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 40) begin
      if (lat == 3) begin
        start1 = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      end else begin
        start1 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0;
    check("ignored start latency", 32'(lat), 32'd8);
    check("ignored start sum", 32'(sum1), 32'h01);
    check("ignored start cout", 32'(cout1), 32'd1);
    @(negedge clk);
    check("ignored start no requeue", 32'(busy1), 32'd0);

    // Start held high through DONE issues the next operation back to back.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start1 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b first latency", 32'(lat), 32'd8);
    check("b2b first sum", 32'(sum1), 32'h10);
    a = 8'h7F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    check("b2b accepted busy", 32'(busy1), 32'd1);
    check("b2b done dropped", 32'(done1), 32'd0);
    gap = 1;
    while (!done1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b done spacing", 32'(gap), 32'd9);
    check("b2b second sum", 32'(sum1), 32'h80);
    check("b2b second ovf", 32'(ovf1), 32'd1);

    // Reset during RUN clears outputs immediately and discards the partial result.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy1), 32'd0);
    check("midrst done", 32'(done1), 32'd0);
    check("midrst sum", 32'(sum1), 32'd0);
    check("midrst cout/ovf", 32'({cout1, ovf1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done1 || busy1) seen = 1'b1;
    end
    check("midrst no done", 32'(seen), 32'd0);
    run_op(1'b0, vecs[2], "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in, processing BITS_PER_CYCLE bits per clock through a registered carry.
- Start/busy/done handshake lets a controller issue one addition at a time and trade latency for adder area.
- Successor to the single-bit full adder in the lab datapath. It generalises that adder in width and adds sequencing and signed-overflow reporting.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- BITS_PER_CYCLE, 1, bits summed per clock. Must divide WIDTH; an elaboration-time check errors otherwise.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  operand A; sampled with an accepted start.
- b  in  WIDTH  operand B; sampled with an accepted start.
- cin  in  1  carry-in; sampled with an accepted start.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result; held until the next completion.
- cout  out  1  unsigned carry-out.
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal operand, partial-sum, carry and count registers = 0.
- N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge accepts the operation.
  - That edge latches a, b into right-shifting operand registers and cin into the carry register, clears the count, and moves to RUN.
  - busy rises after this edge.
- RUN: each edge
  - adds the low BITS_PER_CYCLE bits of both operand registers plus the carry register;
  - shifts the chunk sum into the top of the partial-sum register (LSB chunk first, ends aligned);
  - shifts the operands right by BITS_PER_CYCLE;
  - updates the carry register and increments the count.
- On the Nth RUN edge:
  - sum, cout and overflow load their final values; the carry into the MSB is captured from the last chunk.
  - State moves to DONE.
- DONE lasts one cycle: done=1, busy=0. The next edge returns to IDLE.
- Timing: start is accepted at edge 0, and done is high during the cycle after edge N. For WIDTH=8, BITS_PER_CYCLE=1 that is after edge 8. The controller can issue a new start every N+1 cycles.
- Outputs sum, cout and overflow change only at completion. They hold across later IDLE and RUN cycles.
- start while busy (RUN) is ignored; no queueing.
- start while in DONE is accepted exactly as in IDLE. done is still high that cycle; the state goes to RUN.
- Changes on a, b or cin after acceptance have no effect.
- Reset mid-RUN aborts immediately. All outputs return to reset values; the partial result is discarded.
- Arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the count width function: $clog2(N+1).
- One sub-module: adder_chunk.
  - Combinational BITS_PER_CYCLE-bit ripple of full adders.
  - Outputs: chunk sum, carry out, and the carry into its top bit (used for overflow on the last chunk).
  - Instantiated once per serial_adder_fsm.

Test Plan:
- Reset then idle (WIDTH=8, BITS_PER_CYCLE=1): outputs all 0; done never pulses without start.
- a=8'h0F, b=8'h01, cin=0, start one cycle -> busy for 8 cycles, then done pulse; sum=8'h10, cout=0, overflow=0.
- a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, overflow=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1.
- BITS_PER_CYCLE=4, a=8'hA5, b=8'h5B, cin=0:
  - done after 2 RUN edges;
  - sum=8'h00, cout=1, overflow=0.
- Mid-operation stimulus (BITS_PER_CYCLE=1):
  - start pulsed again at RUN cycle 3 with a=8'h11, b=8'h22 -> ignored; the first result is still produced.
  - start held high through DONE -> back-to-back operation accepted; the second done follows N+1 cycles after the first.
- rst_n dropped at RUN cycle 4 -> busy, done, sum, cout and overflow are 0 immediately. No done pulse until a fresh start; that start then completes correctly.
